// File: rtl/pwm_pkg.sv
// pwm_pkg: constants shared by the SPI register block and the PWM peripheral.
// Holds the PWM counter width, the full-duty code, the default prescale
// divisor and the SPI register addresses of the five configuration registers.
package pwm_pkg;
    localparam int              PWM_CNT_W       = 8;
    localparam logic [7:0]      DUTY_FULL       = 8'hFF;
    localparam int              CLK_DIV_DEFAULT = 13;
    localparam logic [7:0]      ADDR_EN_OUT_7_0  = 8'h00;
    localparam logic [7:0]      ADDR_EN_OUT_15_8 = 8'h01;
    localparam logic [7:0]      ADDR_EN_PWM_7_0  = 8'h02;
    localparam logic [7:0]      ADDR_EN_PWM_15_8 = 8'h03;
    localparam logic [7:0]      ADDR_PWM_DUTY    = 8'h04;
endpackage

// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: configuration and pin bundle between the SPI register block and the PWM peripheral.
// Signals: four 8-bit enable registers, 8-bit duty, 16-bit registered output pins.
// master = register block side (drives config, sees pins); slave = peripheral side.
interface pwm_peripheral_if;
    import pwm_pkg::*;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [PWM_CNT_W-1:0] pwm_duty_cycle;
    logic [15:0] out;
    modport master (
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        input  out
    );
    modport slave (
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
        output out
    );
endinterface

// File: rtl/pwm_tick_gen.sv
// pwm_tick_gen: prescaler producing a one-clock tick every CLK_DIV clocks.
// Ports: clk, rst (sync, active-high), tick (high on the last clock of each prescale interval).
module pwm_tick_gen #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    // Keep at least one bit so CLK_DIV = 1 (tick every clock) still elaborates.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
    logic [PW-1:0] pre;
    assign tick = (pre == LAST);
    always_ff @(posedge clk) begin
        if (rst || tick) pre <= '0;
        else             pre <= pre + 1'b1;
    end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 outputs, each forced low, static high, or driven by one shared 8-bit PWM waveform.
// Ports: clk, rst (sync, active-high), bus (slave modport: enables, duty in; registered pins out).
// Period is 256*CLK_DIV clocks; duty is shadowed so it only changes on period boundaries.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    pwm_peripheral_if.slave  bus
);
    logic                 tick;
    logic [PWM_CNT_W-1:0] cnt;
    logic [PWM_CNT_W-1:0] duty_sh;
    logic                 pwm_sig;
    logic [15:0]          en_out;
    logic [15:0]          en_pwm;
    logic [15:0]          nxt;
    logic [15:0]          out_q;

    pwm_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // Full code means 100%: a plain compare could never be true at cnt = 255.
    assign pwm_sig = (duty_sh == DUTY_FULL) || (cnt < duty_sh);

    // Enabled static outputs are high; enabled PWM outputs follow the waveform.
    assign nxt = en_out & (~en_pwm | {16{pwm_sig}});

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            duty_sh <= '0;
            out_q   <= '0;
        end else begin
            if (tick) cnt <= cnt + 1'b1;
            // Load on the last clock of the period so the new duty starts with cnt = 0.
            if (tick && cnt == '1) duty_sh <= bus.pwm_duty_cycle;
            out_q <= nxt;
        end
    end

    assign bus.out = out_q;
endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Consumes the five configuration registers written over SPI: output enables, PWM-mode enables and duty cycle. Drives 16 digital outputs, each forced low, held static high, or toggled by a shared 8-bit PWM waveform at about 3 kHz from the 10 MHz system clock. Sits directly downstream of the SPI register block, and its outputs go to the chip's output pins.

## Interface
Parameters:
- CLK_DIV, 13: system clocks per PWM counter step; must be ≥1. PWM period = 256·CLK_DIV clocks (3328 at default).

Ports:
- clk  in  1  system clock, 10 MHz nominal.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- en_reg_out_7_0  in  8  output enable, outputs 7..0.
- en_reg_out_15_8  in  8  output enable, outputs 15..8.
- en_reg_pwm_7_0  in  8  PWM-mode enable, outputs 7..0.
- en_reg_pwm_15_8  in  8  PWM-mode enable, outputs 15..8.
- pwm_duty_cycle  in  8  requested duty, in 1/256 steps; 0xFF means 100%.
- out  out  16  registered output pins; out[15:8] from the _15_8 registers, out[7:0] from the _7_0 registers.

## Operation
- **Prescaler `pre`**:
  - Counts 0..CLK_DIV-1 every clock, then wraps to 0.
  - `tick` = (pre == CLK_DIV-1).
- **PWM counter `cnt`** (8 bits):
  - Increments on `tick`.
  - Wraps 255→0 using natural 8-bit overflow; no saturation.
- **Duty shadow `duty_sh`** (8 bits):
  - Loads pwm_duty_cycle when `tick` && cnt == 255, i.e. on the last clock of a period.
  - Holds otherwise.
  - Mid-period writes to pwm_duty_cycle never change the current period.
- **Shared waveform `pwm_sig`**:
  - = 1 if duty_sh == 0xFF.
  - Otherwise = (cnt < duty_sh), an unsigned 8-bit compare.
  - duty_sh = 0 gives constant 0.
- **Per output i**, with en_out and en_pwm being the concatenated 16-bit enables:
  - next = 0 if en_out[i] == 0.
  - next = 1 if en_out[i] && !en_pwm[i].
  - next = pwm_sig if en_out[i] && en_pwm[i].
  - en_pwm[i] alone (en_out[i] = 0) never drives the pin.
- **Reset** (rst high at a clock edge, including mid-period): pre = 0, cnt = 0, duty_sh = 0, out = 0.
  - The first period after reset runs with duty 0; the new duty takes effect from the second period.
  - This matches the upstream registers, which also reset to 0.

## Timing
- **Enable latency**: a change on an enable input is visible on `out` 1 clock later (registered output).
- **Duty latency**: a change takes effect from the first clock of the next period.
  - Worst case is 256·CLK_DIV clocks.
  - A change made on the exact load cycle is captured.
- **High time**: out is high for duty_sh·CLK_DIV clocks per period, starting one clock after cnt becomes 0.
  - Low for the remaining (256−duty_sh)·CLK_DIV clocks.
  - At 0xFF: high for all 256·CLK_DIV clocks, with no low gap.
- **Phase**: all PWM outputs are phase-aligned, because they share one counter and one compare.
- **Simultaneous events**: rst has priority over tick and shadow load. A shadow load and an enable change in the same clock are independent.
- **Inputs**: upstream delivers them already synchronised to clk; no CDC in this block.

## Structure
- **Shared package `pwm_pkg`**: PWM_CNT_W = 8, DUTY_FULL = 8'hFF, default CLK_DIV = 13.
  - The SPI register-address constants (0x00–0x04) move into the same package so both blocks share them.
- **Sub-module `pwm_tick_gen`**: the prescaler, parameter CLK_DIV, output `tick`.
- **Top level**: cnt, duty_sh, compare, 16-bit output mux and output register.

## Test plan
- **Reset mid-period**: all inputs 0xFF, assert rst for 3 clocks at cnt = 100 → out == 0 one clock after the first reset edge; cnt == 0 on release; first period all PWM bits low.
- **Static mode**: en_out = 16'h00FF, en_pwm = 0, duty = 0x80 → out == 16'h00FF from 1 clock after the change, constant for 2 full periods.
- **Half duty**: en_out = en_pwm = 16'hFFFF, duty = 0x80 → after the first full period, every bit high 1664 clocks / low 1664 clocks, period 3328, all 16 bits identical.
- **Duty extremes**:
  - duty = 0x00 → PWM bits constantly 0.
  - duty = 0xFF → PWM bits constantly 1 across period boundaries.
  - en_out[3] = 0 with en_pwm[3] = 1 → out[3] constantly 0.
- **Mid-period duty change**: duty 0x40, switch to 0xC0 at cnt = 100 → current period high 832 clocks; next period high 2496 clocks.
- **CLK_DIV = 1 build**: duty = 0x03 → high 3 / low 253 clocks, period 256.
